// File: rtl/issue_queue_if.sv
// Decode-to-execute issue bundle: two in-order enqueue slots in, two issue slots out.
interface issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int W     = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]        in_valid;
  logic [1:0][W-1:0] in_data;
  logic [1:0][4:0]   in_src1;
  logic [1:0][4:0]   in_src2;
  logic [1:0][4:0]   in_dst;
  logic [1:0]        in_wen;
  logic [1:0]        in_md;
  logic              in_ready;
  logic              stallE;
  logic              flushE;
  logic [1:0]        out_valid;
  logic [1:0][W-1:0] out_data;
  logic [CW-1:0]     count;

  modport master (
    output in_valid, in_data, in_src1, in_src2, in_dst, in_wen, in_md, stallE, flushE,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, in_src1, in_src2, in_dst, in_wen, in_md, stallE, flushE,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/issue_queue.sv
// Dual-enqueue, dual-issue in-order issue queue; slot 1 pairs with slot 0 only when
// no RAW, WAW or double mult/div conflict exists between the two head entries.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         reset,
  issue_queue_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [W-1:0] data_q [DEPTH];
  logic [4:0]   src1_q [DEPTH];
  logic [4:0]   src2_q [DEPTH];
  logic [4:0]   dst_q  [DEPTH];
  logic         wen_q  [DEPTH];
  logic         md_q   [DEPTH];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          ready;
  logic          enq_ok, we0, we1;
  logic [AW-1:0] wa0, wa1, head1;
  logic [1:0]    enq_n, deq_n;
  logic          ov0, ov1, pair_ok;

  // Admission looks only at registered occupancy, so ready never depends on this cycle's issue.
  assign ready  = (count_q <= READY_MAX);
  assign enq_ok = ready && !io.flushE;
  assign we0    = enq_ok && io.in_valid[0];
  assign we1    = enq_ok && io.in_valid[1];
  assign wa0    = tail_q;
  assign wa1    = io.in_valid[0] ? tail_q + AW'(1) : tail_q;
  assign enq_n  = {1'b0, we0} + {1'b0, we1};

  assign head1 = head_q + AW'(1);

  always_comb begin
    pair_ok = 1'b1;
    if (wen_q[head_q] && (dst_q[head_q] != 5'd0) &&
        ((dst_q[head_q] == src1_q[head1]) || (dst_q[head_q] == src2_q[head1])))
      pair_ok = 1'b0;
    if (md_q[head_q] && md_q[head1])
      pair_ok = 1'b0;
    if (wen_q[head_q] && wen_q[head1] && (dst_q[head_q] != 5'd0) &&
        (dst_q[head_q] == dst_q[head1]))
      pair_ok = 1'b0;
  end

  assign ov0   = (count_q != '0) && !io.stallE && !io.flushE;
  assign ov1   = ov0 && (count_q >= CW'(2)) && pair_ok;
  assign deq_n = {1'b0, ov0} + {1'b0, ov1};

  assign io.in_ready  = ready;
  assign io.count     = count_q;
  assign io.out_valid = {ov1, ov0};
  assign io.out_data  = {data_q[head1], data_q[head_q]};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (io.flushE) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(deq_n);
      tail_d  = tail_q + AW'(enq_n);
      count_d = count_q + CW'(enq_n) - CW'(deq_n);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (we0) begin
      data_q[wa0] <= io.in_data[0];
      src1_q[wa0] <= io.in_src1[0];
      src2_q[wa0] <= io.in_src2[0];
      dst_q[wa0]  <= io.in_dst[0];
      wen_q[wa0]  <= io.in_wen[0];
      md_q[wa0]   <= io.in_md[0];
    end
    if (we1) begin
      data_q[wa1] <= io.in_data[1];
      src1_q[wa1] <= io.in_src1[1];
      src2_q[wa1] <= io.in_src2[1];
      dst_q[wa1]  <= io.in_dst[1];
      wen_q[wa1]  <= io.in_wen[1];
      md_q[wa1]   <= io.in_md[1];
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios with fixed expectations plus a random run
// checked against a queue-based reference model.
module tb_issue_queue;
  localparam int DEPTH = 8;
  localparam int W     = 64;

  typedef struct {
    logic [W-1:0] data;
    logic [4:0]   src1;
    logic [4:0]   src2;
    logic [4:0]   dst;
    logic         wen;
    logic         md;
  } op_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  issue_queue_if #(.DEPTH(DEPTH), .W(W)) bus ();
  issue_queue #(.DEPTH(DEPTH), .W(W)) dut (.clk(clk), .reset(reset), .io(bus.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic op_t mk(input logic [W-1:0] d, input logic [4:0] s1, input logic [4:0] s2,
                             input logic [4:0] dst, input logic wen, input logic md);
    op_t o;
    o.data = d; o.src1 = s1; o.src2 = s2; o.dst = dst; o.wen = wen; o.md = md;
    return o;
  endfunction

  function automatic op_t rnd_op();
    return mk({$urandom, $urandom}, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
  endfunction

  // Pairing rules: RAW on a nonzero dst, two mult/div ops, or WAW on a nonzero dst.
  function automatic logic blocked(input op_t a, input op_t b);
    logic raw, mdd, waw;
    raw = a.wen && (a.dst != 0) && ((a.dst == b.src1) || (a.dst == b.src2));
    mdd = a.md && b.md;
    waw = a.wen && b.wen && (a.dst != 0) && (a.dst == b.dst);
    return raw || mdd || waw;
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 2'b00;
    bus.in_data  = '0;
    bus.in_src1  = '0;
    bus.in_src2  = '0;
    bus.in_dst   = '0;
    bus.in_wen   = '0;
    bus.in_md    = '0;
    bus.stallE   = 1'b0;
    bus.flushE   = 1'b0;
  endtask

  task automatic drive(input logic [1:0] v, input op_t a, input op_t b);
    bus.in_valid   = v;
    bus.in_data[0] = a.data; bus.in_data[1] = b.data;
    bus.in_src1[0] = a.src1; bus.in_src1[1] = b.src1;
    bus.in_src2[0] = a.src2; bus.in_src2[1] = b.src2;
    bus.in_dst[0]  = a.dst;  bus.in_dst[1]  = b.dst;
    bus.in_wen[0]  = a.wen;  bus.in_wen[1]  = b.wen;
    bus.in_md[0]   = a.md;   bus.in_md[1]   = b.md;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    op_t a, b;
    a = mk(64'h1111, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    b = mk(64'h2222, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0);
    idle_inputs();
    reset = 1'b0;
    drive(2'b11, a, b);
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_ovalid: got %b expected 00", bus.out_valid); end
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    drive(2'b11, a, b);
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus.count !== 4'd2) begin n_fail++; $display("FAIL prereset_count: got %0d expected 2", bus.count); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL async_reset_ovalid: got %b expected 00", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_dual_issue();
    op_t a, b;
    a = mk(64'hA0A0_0000_0000_0001, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    b = mk(64'hB0B0_0000_0000_0002, 5'd4, 5'd6, 5'd7, 1'b1, 1'b0);
    @(negedge clk);
    drive(2'b11, a, b);
    #1;
    n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL dual_no_bypass: got %b expected 00", bus.out_valid); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus.out_valid !== 2'b11) begin n_fail++; $display("FAIL dual_ovalid: got %b expected 11", bus.out_valid); end
    n_checks++; if (bus.out_data[0] !== a.data) begin n_fail++; $display("FAIL dual_data0: got %h expected %h", bus.out_data[0], a.data); end
    n_checks++; if (bus.out_data[1] !== b.data) begin n_fail++; $display("FAIL dual_data1: got %h expected %h", bus.out_data[1], b.data); end
    @(negedge clk);
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL dual_count_after: got %0d expected 0", bus.count); end
  endtask

  task automatic test_raw_hazard();
    op_t a, b;
    a = mk(64'hAAAA_0000_0000_0005, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    b = mk(64'hBBBB_0000_0000_0006, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0);
    @(negedge clk);
    drive(2'b11, a, b);
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus.out_valid !== 2'b01) begin n_fail++; $display("FAIL raw_ovalid0: got %b expected 01", bus.out_valid); end
    n_checks++; if (bus.out_data[0] !== a.data) begin n_fail++; $display("FAIL raw_data_a: got %h expected %h", bus.out_data[0], a.data); end
    @(negedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 2'b01) begin n_fail++; $display("FAIL raw_ovalid1: got %b expected 01", bus.out_valid); end
    n_checks++; if (bus.out_data[0] !== b.data) begin n_fail++; $display("FAIL raw_data_b: got %h expected %h", bus.out_data[0], b.data); end
    @(negedge clk);
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL raw_count: got %0d expected 0", bus.count); end
  endtask

  task automatic test_pair_rules();
    op_t a, b;
    // Same nonzero destination on both: write-after-write keeps them apart.
    a = mk(64'h0C01, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
    b = mk(64'h0C02, 5'd3, 5'd4, 5'd9, 1'b1, 1'b0);
    @(negedge clk);
    drive(2'b11, a, b);
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus.out_valid !== 2'b01) begin n_fail++; $display("FAIL waw_ovalid: got %b expected 01", bus.out_valid); end
    repeat (2) @(negedge clk);
    // Register zero never creates a dependency.
    a = mk(64'h0D01, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    b = mk(64'h0D02, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    drive(2'b11, a, b);
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus.out_valid !== 2'b11) begin n_fail++; $display("FAIL zero_dst_ovalid: got %b expected 11", bus.out_valid); end
    @(negedge clk);
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL zero_dst_count: got %0d expected 0", bus.count); end
  endtask

  task automatic test_md_pair();
    op_t a, b;
    a = mk(64'h3D01, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    b = mk(64'h3D02, 5'd5, 5'd6, 5'd4, 1'b1, 1'b1);
    @(negedge clk);
    drive(2'b11, a, b);
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus.count !== 4'd2) begin n_fail++; $display("FAIL md_count2: got %0d expected 2", bus.count); end
    n_checks++; if (bus.out_valid !== 2'b01) begin n_fail++; $display("FAIL md_ovalid0: got %b expected 01", bus.out_valid); end
    @(negedge clk);
    #1;
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL md_count1: got %0d expected 1", bus.count); end
    n_checks++; if (bus.out_data[0] !== b.data) begin n_fail++; $display("FAIL md_data_b: got %h expected %h", bus.out_data[0], b.data); end
    @(negedge clk);
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL md_count0: got %0d expected 0", bus.count); end
  endtask

  task automatic test_full_stall();
    op_t seq [8];
    op_t x;
    for (int i = 0; i < 8; i++) seq[i] = mk({32'hF0F0_F0F0, 32'(i)}, 5'd0, 5'd0, 5'(i + 1), 1'b0, 1'b0);
    x = mk(64'hDEAD_BEEF_DEAD_BEEF, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      bus.stallE = 1'b1;
      drive(2'b11, seq[2*i], seq[2*i+1]);
    end
    @(negedge clk);
    drive(2'b11, x, x);
    #1;
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", bus.count); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL stall_ovalid: got %b expected 00", bus.out_valid); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL full_ignore_count: got %0d expected 8", bus.count); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.out_valid !== 2'b11) begin n_fail++; $display("FAIL drain_ovalid[%0d]: got %b expected 11", k, bus.out_valid); end
      n_checks++; if (bus.out_data[0] !== seq[2*k].data) begin n_fail++; $display("FAIL drain_data0[%0d]: got %h expected %h", k, bus.out_data[0], seq[2*k].data); end
      n_checks++; if (bus.out_data[1] !== seq[2*k+1].data) begin n_fail++; $display("FAIL drain_data1[%0d]: got %h expected %h", k, bus.out_data[1], seq[2*k+1].data); end
      @(negedge clk);
      #1;
    end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", bus.count); end
  endtask

  task automatic test_wrap_order();
    op_t wexp [6];
    op_t junk;
    int  idx;
    do_reset();
    junk = mk(64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.stallE = 1'b1;
      drive(2'b11, junk, junk);
      @(negedge clk);
    end
    idle_inputs();
    for (int k = 0; k < 10 && bus.count != 0; k++) @(negedge clk);
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL wrap_predrain: got %0d expected 0", bus.count); end
    for (int i = 0; i < 6; i++) wexp[i] = rnd_op();
    for (int i = 0; i < 3; i++) begin
      bus.stallE = 1'b1;
      drive(2'b11, wexp[2*i], wexp[2*i+1]);
      @(negedge clk);
    end
    idle_inputs();
    #1;
    n_checks++; if (bus.count !== 4'd6) begin n_fail++; $display("FAIL wrap_fill: got %0d expected 6", bus.count); end
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      for (int s = 0; s < 2; s++) begin
        if (bus.out_valid[s]) begin
          n_checks++;
          if (idx >= 6) begin n_fail++; $display("FAIL wrap_extra: got issue %0d expected at most 6", idx + 1); end
          else if (bus.out_data[s] !== wexp[idx].data) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h expected %h", idx, bus.out_data[s], wexp[idx].data); end
          idx++;
        end
      end
      @(negedge clk);
      #1;
    end
    n_checks++; if (idx != 6) begin n_fail++; $display("FAIL wrap_issued: got %0d expected 6", idx); end
  endtask

  task automatic test_flush();
    op_t a, b;
    a = mk(64'hF1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    b = mk(64'hF2, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    bus.stallE = 1'b1;
    drive(2'b11, a, b);
    @(negedge clk);
    drive(2'b11, a, b);
    @(negedge clk);
    drive(2'b01, a, b);
    @(negedge clk);
    idle_inputs();
    bus.stallE = 1'b1;
    #1;
    n_checks++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 5", bus.count); end
    bus.stallE = 1'b0;
    bus.flushE = 1'b1;
    drive(2'b11, a, b);
    #1;
    n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL flush_ovalid_now: got %b expected 00", bus.out_valid); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL flush_ovalid: got %b expected 00", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_random();
    op_t        q[$];
    op_t        a, b;
    logic [1:0] v, exp_ov;
    logic       st, fl, exp_ready;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      v  = 2'($urandom_range(0, 3));
      a  = rnd_op();
      b  = rnd_op();
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 49) == 0);
      drive(v, a, b);
      bus.stallE = st;
      bus.flushE = fl;
      #1;
      exp_ready = (DEPTH - q.size() >= 2);
      exp_ov    = 2'b00;
      if (q.size() >= 1 && !st && !fl) exp_ov[0] = 1'b1;
      if (exp_ov[0] && q.size() >= 2) exp_ov[1] = !blocked(q[0], q[1]);
      n_checks++; if (bus.count !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, bus.count, q.size()); end
      n_checks++; if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, bus.in_ready, exp_ready); end
      n_checks++; if (bus.out_valid !== exp_ov) begin n_fail++; $display("FAIL rnd_ovalid@%0d: got %b expected %b", cyc, bus.out_valid, exp_ov); end
      if (q.size() >= 1) begin
        n_checks++; if (bus.out_data[0] !== q[0].data) begin n_fail++; $display("FAIL rnd_data0@%0d: got %h expected %h", cyc, bus.out_data[0], q[0].data); end
      end
      if (q.size() >= 2) begin
        n_checks++; if (bus.out_data[1] !== q[1].data) begin n_fail++; $display("FAIL rnd_data1@%0d: got %h expected %h", cyc, bus.out_data[1], q[1].data); end
      end
      @(posedge clk);
      if (fl) begin
        q.delete();
      end else begin
        if (exp_ov[0]) void'(q.pop_front());
        if (exp_ov[1]) void'(q.pop_front());
        if (exp_ready && v[0]) q.push_back(a);
        if (exp_ready && v[1]) q.push_back(b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dual_issue();
    test_raw_hazard();
    test_pair_rules();
    test_md_pair();
    test_full_stall();
    test_wrap_order();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue entries; power of two, at least 4.
REQ-002 SHALL have parameter W, default 64, meaning width of the opaque payload per entry.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  2  decode enqueue slots; [0] is older than [1].
REQ-006 SHALL have port in_data  input  2xW  payload per enqueue slot.
REQ-007 SHALL have ports in_src1, in_src2, in_dst  input  2x5 each  source and destination register numbers.
REQ-008 SHALL have ports in_wen, in_md  input  2 each  register-write flag and mult/div flag.
REQ-009 SHALL have port in_ready  output  1  high when at least 2 entries are free.
REQ-010 SHALL have port stallE  input  1  execute cannot accept a new pair this cycle.
REQ-011 SHALL have port flushE  input  1  discard all queued entries.
REQ-012 SHALL have port out_valid  output  2  issue slots to execute; [0] is older.
REQ-013 SHALL have port out_data  output  2xW  payload of issued entries.
REQ-014 SHALL have port count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-015 SHALL store entries in a circular buffer with head/tail pointers that wrap modulo DEPTH.
REQ-016 SHALL drive in_ready = (DEPTH - count >= 2), computed from registered count only.
REQ-017 SHALL, when in_ready=1 and no flush, enqueue in_valid slots in order: 2'b01 or 2'b10 -> one entry; 2'b11 -> two entries, slot 0 first.
REQ-018 SHALL ignore all in_valid when in_ready=0; no state change, no overwrite.
REQ-019 SHALL present head entry on out slot 0 combinationally; out_valid[0] = (count>=1) && !stallE && !flushE.
REQ-020 SHALL present head+1 on out slot 1; out_valid[1] only if out_valid[0], count>=2, and pairing rules REQ-021..023 pass.
REQ-021 Pairing: slot 1 SHALL NOT issue if slot 0 has wen=1, dst!=0, and dst equals slot 1 src1 or src2.
REQ-022 Pairing: slot 1 SHALL NOT issue if both entries have md=1.
REQ-023 Pairing: slot 1 SHALL NOT issue if slot 0 and slot 1 both have wen=1 and equal nonzero dst.
REQ-024 SHALL dequeue exactly popcount(out_valid) entries at the clock edge.
REQ-025 SHALL permit enqueue and dequeue in the same cycle; next count = count + enq - deq.
REQ-026 SHALL, on flushE=1, set head=tail=0 and count=0 at the edge; flush overrides same-cycle enqueue.
REQ-027 SHALL keep an entry written at edge N invisible to out until the cycle after edge N (no enqueue-to-issue bypass).
REQ-028 SHALL drive out_data from stored entries regardless of out_valid; consumers qualify with out_valid.

Reset
REQ-029 While reset=0, SHALL asynchronously force head=0, tail=0, count=0; outputs out_valid=2'b00, in_ready=1, count=0.
REQ-030 SHALL NOT require payload storage to be reset; contents are don't-care until written.
REQ-031 Reset assertion mid-enqueue or mid-issue SHALL discard that transfer entirely.

Verification
REQ-032 Reset, then in_valid=2'b11 with independent ops A,B, stallE=0 -> next cycle out_valid=2'b11, out_data={B,A}; following cycle count=0.
REQ-033 Enqueue A (wen=1, dst=5), B (src1=5) -> out_valid=2'b01 issuing A; next cycle B alone on slot 0.
REQ-034 Enqueue two md=1 ops -> issued one per cycle over 2 cycles; count 2->1->0.
REQ-035 Hold stallE=1, enqueue pairs for 4 cycles with DEPTH=8 -> count=8, in_ready=0; further in_valid=2'b11 ignored, count stays 8.
REQ-036 Fill 6 entries, pointers crossing index 7->0 after drain and refill; release stall -> entries issued in exact enqueue order.
REQ-037 count=5, flushE=1 with in_valid=2'b11 same cycle -> next cycle count=0, out_valid=2'b00, in_ready=1.
